// File: rtl/coin_pulse_conditioner.sv
// Coin-sensor front end: 2-flop sync, per-channel debounce, and an arbiter that
// serialises simultaneous coins into single-cycle Nickel/Dime pulses or rejects them.
module coin_pulse_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REJ_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             nickel_raw,
  input  logic             dime_raw,
  input  logic             accept_en,
  output logic             Nickel,
  output logic             Dime,
  output logic             coin_reject,
  output logic [REJ_W-1:0] reject_cnt,
  output logic             pend_dime
);

  localparam int CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int NCH  = 2;
  localparam int CH_N = 0;
  localparam int CH_D = 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [NCH-1:0] raw;
  logic [NCH-1:0] rise;

  assign raw = {dime_raw, nickel_raw};

  // One synchroniser + debouncer + edge detector per coin channel.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    logic          s1_q;
    logic          s2_q;
    logic          st_q;
    logic          st_d;
    logic          st_dly_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      if (s2_q == st_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        st_d  = s2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        s1_q     <= 1'b0;
        s2_q     <= 1'b0;
        st_q     <= 1'b0;
        st_dly_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        s1_q     <= raw[gi];
        s2_q     <= s1_q;
        st_q     <= st_d;
        st_dly_q <= st_q;
        cnt_q    <= cnt_d;
      end
    end

    assign rise[gi] = st_q & ~st_dly_q;
  end

  typedef enum logic [0:0] {
    ARB_IDLE      = 1'b0,
    ARB_PEND_DIME = 1'b1
  } arb_state_e;

  arb_state_e       state_q;
  arb_state_e       state_d;
  logic             nickel_q;
  logic             nickel_d;
  logic             dime_q;
  logic             dime_d;
  logic             rej_q;
  logic             rej_d;
  logic [REJ_W-1:0] rej_cnt_q;
  logic [REJ_W-1:0] rej_cnt_d;
  logic [1:0]       n_events;
  logic [REJ_W:0]   rej_sum;

  assign n_events = {1'b0, rise[CH_N]} + {1'b0, rise[CH_D]};
  // One extra bit catches the carry so the counter can saturate instead of wrapping.
  assign rej_sum  = {1'b0, rej_cnt_q} + {{(REJ_W-1){1'b0}}, n_events};

  always_comb begin
    state_d   = state_q;
    nickel_d  = 1'b0;
    dime_d    = 1'b0;
    rej_d     = 1'b0;
    rej_cnt_d = rej_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (|rise) begin
          if (!accept_en) begin
            rej_d     = 1'b1;
            rej_cnt_d = rej_sum[REJ_W] ? {REJ_W{1'b1}} : rej_sum[REJ_W-1:0];
          end else begin
            nickel_d = rise[CH_N];
            dime_d   = rise[CH_D] & ~rise[CH_N];
            if (&rise) begin
              state_d = ARB_PEND_DIME;
            end
          end
        end
      end
      // The dime was credited when both arrived; it is only being deferred.
      ARB_PEND_DIME: begin
        dime_d  = 1'b1;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ARB_IDLE;
      nickel_q  <= 1'b0;
      dime_q    <= 1'b0;
      rej_q     <= 1'b0;
      rej_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      nickel_q  <= nickel_d;
      dime_q    <= dime_d;
      rej_q     <= rej_d;
      rej_cnt_q <= rej_cnt_d;
    end
  end

  assign Nickel      = nickel_q;
  assign Dime        = dime_q;
  assign coin_reject = rej_q;
  assign reject_cnt  = rej_cnt_q;
  assign pend_dime   = (state_q == ARB_PEND_DIME);

endmodule

// File: tb/tb_coin_pulse_conditioner.sv
// Bench for coin_pulse_conditioner: directed scenarios plus random sensor noise,
// checked by a sample-window reference model feeding a scoreboard queue.
module tb_coin_pulse_conditioner;

  localparam int DEB     = 4;
  localparam int REJ_W   = 8;
  localparam int REJ_MAX = (1 << REJ_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             nickel_raw = 1'b0;
  logic             dime_raw = 1'b0;
  logic             accept_en = 1'b1;
  logic             Nickel;
  logic             Dime;
  logic             coin_reject;
  logic [REJ_W-1:0] reject_cnt;
  logic             pend_dime;

  coin_pulse_conditioner #(.DEBOUNCE_CYCLES(DEB), .REJ_W(REJ_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .nickel_raw (nickel_raw),
    .dime_raw   (dime_raw),
    .accept_en  (accept_en),
    .Nickel     (Nickel),
    .Dime       (Dime),
    .coin_reject(coin_reject),
    .reject_cnt (reject_cnt),
    .pend_dime  (pend_dime)
  );

  always #5 clk = ~clk;

  typedef struct {
    int edge_no;
    bit n;
    bit d;
    bit rej;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  // Reference model state
  bit   hist_n[$];
  bit   hist_d[$];
  bit   m_st_n, m_st_d, m_ev_n, m_ev_d, m_pend;
  int   m_rej;

  // Monitor observations
  int   n_pulses = 0, d_pulses = 0, rej_pulses = 0, pend_cycles = 0;
  int   last_n_edge = -1, last_d_edge = -1, last_pend_edge = -1;

  // A stable level flips once the last DEB synchronised samples (raw delayed two
  // edges) all disagree with it.
  function automatic bit window_differs(input bit h[$], input bit s);
    if (h.size() < DEB + 1) return 1'b0;
    for (int i = 1; i <= DEB; i++) begin
      if (h[h.size() - 1 - i] == s) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    bit   rise_n, rise_d;
    int   nev;
    cyc++;
    if (reset) begin
      hist_n.delete();
      hist_d.delete();
      m_st_n = 0; m_st_d = 0; m_ev_n = 0; m_ev_d = 0; m_pend = 0; m_rej = 0;
    end else begin
      e = '{cyc, 1'b0, 1'b0, 1'b0};
      if (m_pend) begin
        e.d    = 1'b1;
        m_pend = 1'b0;
      end else if (m_ev_n || m_ev_d) begin
        if (accept_en) begin
          e.n = m_ev_n;
          e.d = m_ev_d && !m_ev_n;
          if (m_ev_n && m_ev_d) m_pend = 1'b1;
        end else begin
          nev   = int'(m_ev_n) + int'(m_ev_d);
          m_rej = (m_rej + nev > REJ_MAX) ? REJ_MAX : m_rej + nev;
          e.rej = 1'b1;
        end
      end
      if (e.n || e.d || e.rej) sbq.push_back(e);
      rise_n = 1'b0;
      rise_d = 1'b0;
      if (window_differs(hist_n, m_st_n)) begin m_st_n = !m_st_n; rise_n = m_st_n; end
      if (window_differs(hist_d, m_st_d)) begin m_st_d = !m_st_d; rise_d = m_st_d; end
      m_ev_n = rise_n;
      m_ev_d = rise_d;
      hist_n.push_back(nickel_raw);
      hist_d.push_back(dime_raw);
      if (hist_n.size() > DEB + 2) void'(hist_n.pop_front());
      if (hist_d.size() > DEB + 2) void'(hist_d.pop_front());
    end
  end

  // Monitor: per-cycle invariants, then pop an expectation whenever the DUT pulses.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      total++;
      if (Nickel && Dime) begin
        bad++;
        $display("FAIL excl cyc=%0d Nickel=%b Dime=%b required not both 1", cyc, Nickel, Dime);
      end
      total++;
      if (reject_cnt !== REJ_W'(m_rej)) begin
        bad++;
        $display("FAIL reject_cnt cyc=%0d got=%0d exp=%0d", cyc, reject_cnt, m_rej);
      end
      total++;
      if (pend_dime !== m_pend) begin
        bad++;
        $display("FAIL pend_dime cyc=%0d got=%b exp=%b", cyc, pend_dime, m_pend);
      end
      if (sbq.size() > 0 && sbq[0].edge_no < cyc) begin
        e = sbq.pop_front();
        total++;
        bad++;
        $display("FAIL missed_pulse cyc=%0d got=none exp edge=%0d n=%b d=%b rej=%b",
                 cyc, e.edge_no, e.n, e.d, e.rej);
      end
      if (Nickel || Dime || coin_reject) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pulse cyc=%0d got n=%b d=%b rej=%b exp=none",
                   cyc, Nickel, Dime, coin_reject);
        end else begin
          e = sbq.pop_front();
          if (e.edge_no != cyc || e.n !== Nickel || e.d !== Dime || e.rej !== coin_reject) begin
            bad++;
            $display("FAIL pulse cyc=%0d got n=%b d=%b rej=%b exp edge=%0d n=%b d=%b rej=%b",
                     cyc, Nickel, Dime, coin_reject, e.edge_no, e.n, e.d, e.rej);
          end
        end
      end
      if (Nickel) begin n_pulses++; last_n_edge = cyc; end
      if (Dime) begin d_pulses++; last_d_edge = cyc; end
      if (coin_reject) rej_pulses++;
      if (pend_dime) begin pend_cycles++; last_pend_edge = cyc; end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  // Drives both sensors for 'hold' sampled edges, then low for 'gap'; returns edge 1.
  task automatic press(input bit n, input bit d, input int hold, input int gap,
                       output int first_edge);
    @(negedge clk);
    nickel_raw = n;
    dime_raw   = d;
    first_edge = cyc + 1;
    repeat (hold) @(negedge clk);
    nickel_raw = 1'b0;
    dime_raw   = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    int e1, n0, d0, r0, p0, rst_edge;
    int rem_n, rem_d;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_Nickel", int'(Nickel), 0);
    chk("reset_Dime", int'(Dime), 0);
    chk("reset_coin_reject", int'(coin_reject), 0);
    chk("reset_reject_cnt", int'(reject_cnt), 0);
    chk("reset_pend_dime", int'(pend_dime), 0);

    // Clean nickel held 20 cycles
    accept_en = 1'b1;
    n0 = n_pulses; d0 = d_pulses;
    press(1'b1, 1'b0, 20, 15, e1);
    chk("t1_nickel_edge", last_n_edge, e1 + 6);
    chk("t1_nickel_count", n_pulses - n0, 1);
    chk("t1_dime_count", d_pulses - d0, 0);

    // Short dime glitch is filtered
    d0 = d_pulses;
    press(1'b0, 1'b1, 3, 15, e1);
    chk("t2_glitch_dime_count", d_pulses - d0, 0);

    // Simultaneous coins serialised
    n0 = n_pulses; d0 = d_pulses; p0 = pend_cycles;
    press(1'b1, 1'b1, 12, 15, e1);
    chk("t3_nickel_edge", last_n_edge, e1 + 6);
    chk("t3_dime_edge", last_d_edge, e1 + 7);
    chk("t3_pend_cycles", pend_cycles - p0, 1);
    chk("t3_pend_edge", last_pend_edge, e1 + 6);
    chk("t3_counts", (n_pulses - n0) * 10 + (d_pulses - d0), 11);

    // Rejection while disabled
    accept_en = 1'b0;
    n0 = n_pulses; d0 = d_pulses; r0 = rej_pulses;
    press(1'b1, 1'b1, 10, 15, e1);
    chk("t4_reject_pulses", rej_pulses - r0, 1);
    chk("t4_reject_cnt", int'(reject_cnt), 2);
    chk("t4_no_coins", (n_pulses - n0) + (d_pulses - d0), 0);

    // Saturation
    repeat (126) press(1'b1, 1'b1, 8, 8, e1);
    chk("t5_reject_cnt_254", int'(reject_cnt), 254);
    press(1'b1, 1'b1, 8, 8, e1);
    chk("t5_reject_cnt_255", int'(reject_cnt), 255);
    press(1'b1, 1'b0, 8, 8, e1);
    chk("t5_reject_cnt_hold", int'(reject_cnt), 255);

    // Reset while a dime is pending, dime sensor held through reset
    accept_en = 1'b1;
    n0 = n_pulses; d0 = d_pulses;
    @(negedge clk);
    nickel_raw = 1'b1;
    dime_raw   = 1'b1;
    e1 = cyc + 1;
    repeat (7) @(negedge clk);
    chk("t6_pend_before_reset", int'(pend_dime), 1);
    reset      = 1'b1;
    nickel_raw = 1'b0;
    rst_edge   = cyc + 1;
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    dime_raw = 1'b0;
    repeat (12) @(negedge clk);
    chk("t6_nickel_count", n_pulses - n0, 1);
    chk("t6_dime_count", d_pulses - d0, 1);
    chk("t6_dime_edge", last_d_edge, rst_edge + 7);
    chk("t6_reject_cnt_cleared", int'(reject_cnt), 0);

    // Random sensor noise, enable toggling and occasional resets
    rem_n = 0;
    rem_d = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 7) == 0) accept_en = $urandom_range(0, 1);
      if (rem_n == 0) begin nickel_raw = $urandom_range(0, 1); rem_n = $urandom_range(1, 10); end
      if (rem_d == 0) begin dime_raw = $urandom_range(0, 1); rem_d = $urandom_range(1, 10); end
      rem_n--;
      rem_d--;
    end
    @(negedge clk);
    reset      = 1'b0;
    nickel_raw = 1'b0;
    dime_raw   = 1'b0;
    repeat (30) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
